// File: rtl/stim_pattern_gen_if.sv
// Control, configuration and stimulus bus of the stimulus pattern generator.
// The master drives run control and channel config; the slave returns stimulus and status.
interface stim_pattern_gen_if #(
  parameter int unsigned NUM_CH = 41,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LEN_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start;
  logic              stop;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_offset;
  logic [1:0]        cfg_mode;
  logic [LEN_W-1:0]  run_len;
  logic [NUM_CH-1:0] stim_out;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [LEN_W-1:0]  cycle_cnt;

  modport master (
    output start, stop, cfg_we, cfg_ch, cfg_period, cfg_offset, cfg_mode, run_len,
    input  stim_out, busy, done, cfg_err, cycle_cnt
  );

  modport slave (
    input  start, stop, cfg_we, cfg_ch, cfg_period, cfg_offset, cfg_mode, run_len,
    output stim_out, busy, done, cfg_err, cycle_cnt
  );
endinterface

// File: rtl/stim_pattern_gen.sv
// Multi-channel stimulus generator: per-channel period/offset/mode with a shared LFSR,
// bounded by an optional run length that ends the run with a one-cycle done pulse.
module stim_pattern_gen #(
  parameter int unsigned NUM_CH    = 41,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned LEN_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               reset,
  stim_pattern_gen_if.slave bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [1:0] ModeHold0  = 2'b00;
  localparam logic [1:0] ModeToggle = 2'b01;
  localparam logic [1:0] ModeRandom = 2'b10;
  localparam logic [1:0] ModeHold1  = 2'b11;

  logic [0:0]                   state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] offset_q, offset_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0]            stim_q, stim_d;
  logic [15:0]                  lfsr_q, lfsr_d, lfsr_next;
  logic [LEN_W-1:0]             run_len_q, run_len_d;
  logic [LEN_W-1:0]             cycle_cnt_q, cycle_cnt_d;
  logic                         done_q, done_d;
  logic                         cfg_err_q, cfg_err_d;
  logic                         cfg_ch_ok;
  logic                         expire;

  assign cfg_ch_ok = 32'(bus.cfg_ch) < NUM_CH;
  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign expire    = (run_len_q != '0) && (cycle_cnt_q == run_len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    offset_d    = offset_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    stim_d      = stim_q;
    lfsr_d      = lfsr_q;
    run_len_d   = run_len_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    if (bus.cfg_we) begin
      if (state_q == StIdle && cfg_ch_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.cfg_ch == CH_W'(i)) begin
            period_d[i] = bus.cfg_period;
            offset_d[i] = bus.cfg_offset;
            mode_d[i]   = bus.cfg_mode;
          end
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (state_q == StIdle) begin
      if (bus.start && !bus.stop) begin
        state_d     = StRun;
        stim_d      = '0;
        cnt_d       = offset_q;
        cycle_cnt_d = '0;
        lfsr_d      = LFSR_SEED;
        run_len_d   = bus.run_len;
      end
    end else begin
      cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + LEN_W'(1);
      lfsr_d      = lfsr_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = period_q[i];
          unique case (mode_q[i])
            ModeHold0:  stim_d[i] = 1'b0;
            ModeToggle: stim_d[i] = ~stim_q[i];
            ModeRandom: stim_d[i] = lfsr_q[4'(i % 16)];
            ModeHold1:  stim_d[i] = 1'b1;
            default:    stim_d[i] = stim_q[i];
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
      // Expiry takes priority over stop so a coincident stop still yields done
      if (expire) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else if (bus.stop) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      period_q    <= '0;
      offset_q    <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      stim_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      run_len_q   <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      offset_q    <= offset_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      lfsr_q      <= lfsr_d;
      run_len_q   <= run_len_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.stim_out  = stim_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen: expectations queued on a scoreboard as stimulus
// is driven, popped and checked with immediate assertions as the outputs appear.
module tb_stim_pattern_gen;
  localparam int unsigned NUM_CH = 41;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LEN_W  = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  string       tag_q[$];
  logic [63:0] val_q[$];

  stim_pattern_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  stim_pattern_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .LEN_W    (LEN_W),
    .LFSR_SEED(SEED)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       tag;
    logic [63:0] v;
    tests_run++;
    if (val_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty: observed %0h required nothing queued", obs);
      return;
    end
    tag = tag_q.pop_front();
    v   = val_q.pop_front();
    assert (obs === v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, v);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic cfg(input int ch, input int per, input int off, input logic [1:0] mode);
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = 6'(ch);
    bus.cfg_period = 8'(per);
    bus.cfg_offset = 8'(off);
    bus.cfg_mode   = mode;
    tick();
    bus.cfg_we     = 1'b0;
  endtask

  task automatic start_run(input int len);
    bus.run_len = 16'(len);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    logic [15:0] l;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_period = '0; bus.cfg_offset = '0; bus.cfg_mode = '0; bus.run_len = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    push("rst_busy", 0);      check(64'(bus.busy));
    push("rst_done", 0);      check(64'(bus.done));
    push("rst_cfg_err", 0);   check(64'(bus.cfg_err));
    push("rst_cycle_cnt", 0); check(64'(bus.cycle_cnt));
    push("rst_stim", 0);      check(64'(bus.stim_out));

    // Start and stop together in IDLE: stop wins
    bus.start = 1'b1; bus.stop = 1'b1; bus.run_len = 16'd5;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    push("startstop_busy", 0); check(64'(bus.busy));

    // Test 1: default configs, run_len=5
    start_run(5);
    for (int k = 0; k < 5; k++) begin
      push("t1_busy", 1); check(64'(bus.busy));
      push("t1_stim", 0); check(64'(bus.stim_out));
      tick();
    end
    push("t1_busy_end", 0);  check(64'(bus.busy));
    push("t1_done", 1);      check(64'(bus.done));
    push("t1_cycle_cnt", 5); check(64'(bus.cycle_cnt));
    tick();
    push("t1_done_once", 0); check(64'(bus.done));
    push("t1_cnt_hold", 5);  check(64'(bus.cycle_cnt));

    // Test 2: ch0 toggle P=3 O=1, unbounded, then stop
    cfg(0, 3, 1, 2'b01);
    for (int k = 0; k < 12; k++)
      push("t2_ch0", (k < 2) ? 64'd0 : 64'(((k - 2) / 4) % 2 == 0));
    start_run(0);
    for (int k = 0; k < 12; k++) begin
      check(64'(bus.stim_out[0]));
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    push("t2_stop_busy", 0); check(64'(bus.busy));
    push("t2_stop_done", 0); check(64'(bus.done));
    tick();
    tick();
    push("t2_ch0_hold", 1);  check(64'(bus.stim_out[0]));
    push("t2_done_none", 0); check(64'(bus.done));

    // Test 3: ch5 hold1 O=0, ch6 toggle P=0 O=0
    cfg(5, 0, 0, 2'b11);
    cfg(6, 0, 0, 2'b01);
    start_run(4);
    push("t3_ch5_init", 0); check(64'(bus.stim_out[5]));
    for (int k = 1; k <= 4; k++) begin
      tick();
      push("t3_ch5", 1);             check(64'(bus.stim_out[5]));
      push("t3_ch6", 64'(k % 2));    check(64'(bus.stim_out[6]));
    end
    push("t3_done", 1);      check(64'(bus.done));
    push("t3_cycle_cnt", 4); check(64'(bus.cycle_cnt));
    tick();

    // Test 4: ch2 random P=0, two identical runs from the seed
    cfg(2, 0, 0, 2'b10);
    for (int r = 0; r < 2; r++) begin
      l = SEED;
      for (int k = 1; k <= 8; k++) begin
        push("t4_ch2", 64'(l[2]));
        l = lfsr_step(l);
      end
      push("t4_done", 1);
      start_run(8);
      for (int k = 1; k <= 8; k++) begin
        tick();
        check(64'(bus.stim_out[2]));
      end
      check(64'(bus.done));
      tick();
    end

    // Test 5: cfg_we in RUN and out-of-range channel in IDLE are dropped
    start_run(0);
    tick();
    bus.cfg_we = 1'b1; bus.cfg_ch = 6'd0; bus.cfg_period = 8'd0;
    bus.cfg_offset = 8'd0; bus.cfg_mode = 2'b11;
    tick();
    bus.cfg_we = 1'b0;
    push("t5_err_run", 1);   check(64'(bus.cfg_err));
    tick();
    push("t5_err_pulse", 0); check(64'(bus.cfg_err));
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    cfg(41, 0, 0, 2'b11);
    push("t5_err_range", 1); check(64'(bus.cfg_err));
    tick();
    push("t5_err_clear", 0); check(64'(bus.cfg_err));
    start_run(3);
    push("t5_ch0_e0", 0); check(64'(bus.stim_out[0]));
    tick();
    push("t5_ch0_e1", 0); check(64'(bus.stim_out[0]));
    tick();
    push("t5_ch0_e2", 1); check(64'(bus.stim_out[0]));
    tick();
    push("t5_done", 1);   check(64'(bus.done));

    // Test 6: reset mid-run restores defaults
    start_run(0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("t6_busy", 0);      check(64'(bus.busy));
    push("t6_stim", 0);      check(64'(bus.stim_out));
    push("t6_cycle_cnt", 0); check(64'(bus.cycle_cnt));
    start_run(4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      push("t6_stim_run", 0); check(64'(bus.stim_out));
    end
    push("t6_done", 1); check(64'(bus.done));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
